vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receive side of the VGA pixel interface: consumes h_sync, v_sync and 4-bit RGB as driven by the pattern generators and vga_sync.
- Recovers line/frame timing from the sync edges, measures total line length and total frame length, and checks timing stability.
- Outputs pixel coordinates and sampled colour, qualified by a lock status.
- Used for loopback self-check of pattern modules and as the front end of a future frame-capture path.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 960, active lines per frame
- H_START, 424, clocks from hsync leading edge to first active pixel (sync 112 + back porch 312)
- V_START, 39, lines from vsync leading edge to first active line (sync 3 + back porch 36)
- SYNC_POL, 1, asserted level of h_sync/v_sync (1 = active-high)
- LOCK_FRAMES, 2, consecutive matching frames required before lock
- CNT_W, 12, counter width; maximum value 4095

Ports:
- clk_in, in, 1, pixel clock; all inputs are synchronous to it
- reset, in, 1, asynchronous, active-high
- h_sync_in, in, 1, horizontal sync
- v_sync_in, in, 1, vertical sync
- r_in / g_in / b_in, in, 4 each, colour inputs
- pix_x, out, CNT_W, active column 0..H_ACTIVE-1
- pix_y, out, CNT_W, active row 0..V_ACTIVE-1
- pix_valid, out, 1, asserted when locked and inside the active window
- r_out / g_out / b_out, out, 4 each, registered colour; 0 when pix_valid=0
- line_start, out, 1, one-cycle pulse on hsync leading edge
- frame_start, out, 1, one-cycle pulse on vsync leading edge
- locked, out, 1, timing stable
- h_total, out, CNT_W, last measured clocks per line
- v_total, out, CNT_W, last measured lines per frame

Behaviour:
- Reset values: all outputs 0, FSM in SEARCH, all counters 0. Reset asserted mid-frame clears everything immediately; there is no partial-frame carry-over.
- Input stage: s1 registers all inputs; s2 holds the previous s1 sync values.
  - Leading edge = s1 asserted AND s2 not asserted (asserted level per SYNC_POL).
- Horizontal counter hc:
  - Loads 0 on the cycle the hsync edge is detected; otherwise increments.
  - Saturates at 4095 and sets sat_h.
- Line counter vc:
  - Loads 0 on the vsync edge.
  - Otherwise increments on each hsync edge; saturates at 4095.
  - If both edges occur in the same cycle, vsync wins: vc=0, hc=0.
- Measurement:
  - On each hsync edge, cur_h = hc+1, compared with ref_h; mismatch or sat_h sets err.
  - On each vsync edge, cur_v = vc+1 is captured.
  - h_total and v_total update on every respective edge.
- FSM states and transitions:
  - SEARCH -> MEASURE on the first vsync edge: ref_h loaded from the first full line, err cleared, good=0.
  - MEASURE -> MEASURE on each vsync edge:
    - If err=0 and cur_v==ref_v, good increments.
    - Otherwise good=0 and ref_h/ref_v reload.
    - err clears after evaluation.
  - MEASURE -> LOCKED when good reaches LOCK_FRAMES; locked asserts in the cycle after that vsync edge.
  - LOCKED -> MEASURE on any line-length mismatch, frame-length mismatch or saturation: locked deasserts the cycle after detection, good=0.
  - Any state -> SEARCH when no hsync edge occurs for 4095 cycles (hc saturated), or no vsync edge occurs for 4095 lines.
- Active window: hc in [H_START, H_START+H_ACTIVE) and vc in [V_START, V_START+V_ACTIVE).
  - pix_x = hc-H_START; pix_y = vc-V_START.
  - Outside the window pix_x/pix_y hold their last value.
- Latency: an RGB sample presented at cycle n appears on r/g/b_out with its pix_x/pix_y/pix_valid at cycle n+2.
  - line_start and frame_start are aligned to the same pipeline position, i.e. edge at the input +2.
- Widths: all comparisons are unsigned CNT_W. H_START+H_ACTIVE must be < 4096; this is checked at elaboration.

Decomposition:
- Shared package (vga_pkg): FSM state enum (SEARCH, MEASURE, LOCKED), CNT_W, and the 1280x960 timing constants, shared with vga_sync.
- One sub-module, sync_edge_detect: synchronising register plus polarity-corrected leading-edge pulse, instantiated once per sync.

Test Plan:
- Drive from a vga_sync instance (1800x1000 totals), reset released at t0:
  - locked=1 one cycle after the 3rd vsync edge (first edge, plus 2 good frames).
  - h_total=1800, v_total=1000.
- Locked, generator drives r=x[3:0], g=y[3:0], b=0xA:
  - Every pix_valid cycle shows r_out==pix_x[3:0], g_out==pix_y[3:0].
  - Exactly 1280x960 valid cycles per frame; first valid has x=0, y=0.
- Locked, one line shortened to 1799 clocks:
  - locked falls at that hsync edge +1.
  - Relocks after 2 clean frames; h_total reads 1799 then 1800.
- hsync held deasserted:
  - After 4095 cycles FSM=SEARCH, locked=0, pix_valid=0, rgb_out=0.
- reset pulsed mid-line while locked:
  - All outputs 0 in the same cycle.
  - Relock requires the full SEARCH → MEASURE → LOCKED sequence (3 vsync edges).
- hsync and vsync leading edges in the same cycle:
  - hc=0, vc=0, both line_start and frame_start pulse, no error flagged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions for the 1280x960 timing family.
// Holds the counter width, the default active/start timing constants
// and the sync-decoder FSM state encoding.
package vga_pkg;
    localparam int CNT_W        = 12;
    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 960;
    // Sync pulse plus back porch: 112 + 312 clocks, 3 + 36 lines.
    localparam int H_START_DEF  = 112 + 312;
    localparam int V_START_DEF  = 3 + 36;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } sync_state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// Input register for one sync line plus a leading-edge pulse.
// The sync is converted to "asserted = 1" on the way in. The edge is
// combinational from the two stages: s1 asserted and s2 not asserted.
// Ports:
//   clk_in, reset  pixel clock, async active-high reset
//   sync_in        raw sync from the pin
//   sync_edge      one-cycle leading-edge pulse, aligned to the s1 stage
module sync_edge_detect #(
    parameter bit SYNC_POL = 1'b1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sync_in,
    output logic sync_edge
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = (sync_in == SYNC_POL);
        s2_d = s1_q;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign sync_edge = s1_q & ~s2_q;
endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing recovery.
// Recovers line/frame timing from sync leading edges, measures line and
// frame length, locks after LOCK_FRAMES consistent frames, and emits pixel
// coordinates with sampled colour two clocks after the input.
// Ports:
//   clk_in, reset              pixel clock, async active-high reset
//   h_sync_in, v_sync_in       syncs, asserted level SYNC_POL
//   r_in, g_in, b_in           4-bit colour
//   pix_x, pix_y, pix_valid    active coordinates, valid when locked+in window
//   r_out, g_out, b_out        colour, forced to 0 when pix_valid=0
//   line_start, frame_start    sync leading-edge pulses, pixel-aligned
//   locked                     timing stable
//   h_total, v_total           last measured clocks/line, lines/frame
module vga_sync_decoder #(
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE_DEF,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE_DEF,
    parameter int H_START     = vga_pkg::H_START_DEF,
    parameter int V_START     = vga_pkg::V_START_DEF,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = vga_pkg::CNT_W
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic [3:0]       r_in,
    input  logic [3:0]       g_in,
    input  logic [3:0]       b_in,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_valid,
    output logic [3:0]       r_out,
    output logic [3:0]       g_out,
    output logic [3:0]       b_out,
    output logic             line_start,
    output logic             frame_start,
    output logic             locked,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total
);
    import vga_pkg::*;

    if (H_START + H_ACTIVE >= (1 << CNT_W)) begin : g_bad_window
        $error("H_START+H_ACTIVE must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_START + V_ACTIVE);
    localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_FRAMES);

    logic h_edge, v_edge;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_h_edge (
        .clk_in(clk_in), .reset(reset), .sync_in(h_sync_in), .sync_edge(h_edge));
    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_v_edge (
        .clk_in(clk_in), .reset(reset), .sync_in(v_sync_in), .sync_edge(v_edge));

    sync_state_e      state_q, state_d;
    logic [3:0]       r_s1_q, r_s1_d, g_s1_q, g_s1_d, b_s1_q, b_s1_d;
    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CNT_W-1:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d, good_q, good_d;
    logic             ref_h_vld_q, ref_h_vld_d, ref_v_vld_q, ref_v_vld_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic             pix_valid_q, pix_valid_d, locked_q, locked_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [3:0]       r_q, r_d, g_q, g_d, b_q, b_d;

    logic             sat_h, sat_v, h_err, err_now, frame_ok, timeout, win;
    logic [CNT_W-1:0] cur_h, cur_v;

    always_comb begin
        r_s1_d = r_in;
        g_s1_d = g_in;
        b_s1_d = b_in;

        sat_h = (hc_q == CNT_MAX);
        sat_v = (vc_q == CNT_MAX);
        cur_h = hc_q + CNT_ONE;
        cur_v = vc_q + CNT_ONE;

        // Counters describe the pixel currently in s1: the sync-edge pixel is hc=0.
        hc_d = hc_q;
        vc_d = vc_q;
        if (h_edge || v_edge) hc_d = '0;
        else if (!sat_h)      hc_d = cur_h;
        if (v_edge)                 vc_d = '0;
        else if (h_edge && !sat_v)  vc_d = cur_v;

        h_total_d = h_edge ? cur_h : h_total_q;
        v_total_d = v_edge ? cur_v : v_total_q;

        state_d     = state_q;
        ref_h_d     = ref_h_q;
        ref_h_vld_d = ref_h_vld_q;
        ref_v_d     = ref_v_q;
        ref_v_vld_d = ref_v_vld_q;
        good_d      = good_q;
        err_d       = err_q;

        h_err   = sat_h || (h_edge && ref_h_vld_q && (cur_h != ref_h_q));
        err_now = err_q || h_err;
        if (h_err) err_d = 1'b1;

        // Reference line length comes from the first full line after a (re)load;
        // the line ending at the SEARCH exit edge may be a partial one.
        if (h_edge && !ref_h_vld_q && (state_q != SEARCH)) begin
            ref_h_d     = cur_h;
            ref_h_vld_d = 1'b1;
        end

        // The first full frame after a reload sets ref_v and counts as good
        // if its lines were consistent.
        frame_ok = !err_now && (!ref_v_vld_q || (cur_v == ref_v_q));

        unique case (state_q)
            SEARCH: if (v_edge) begin
                state_d     = MEASURE;
                good_d      = '0;
                err_d       = 1'b0;
                ref_h_vld_d = 1'b0;
                ref_v_vld_d = 1'b0;
            end
            MEASURE: if (v_edge) begin
                err_d       = 1'b0;
                ref_v_d     = cur_v;
                ref_v_vld_d = 1'b1;
                if (frame_ok) begin
                    good_d = good_q + CNT_ONE;
                    if (good_q + CNT_ONE >= LOCK_N) state_d = LOCKED;
                end else begin
                    good_d      = '0;
                    ref_h_vld_d = 1'b0;
                end
            end
            LOCKED: if (v_edge) begin
                err_d = 1'b0;
                if (!frame_ok) begin
                    state_d     = MEASURE;
                    good_d      = '0;
                    ref_v_d     = cur_v;
                    ref_h_vld_d = 1'b0;
                end
            end else if (h_err) begin
                state_d = MEASURE;
                good_d  = '0;
            end
            default: state_d = SEARCH;
        endcase

        // Missing hsync (hc pinned) or missing vsync (vc pinned) drops to SEARCH.
        timeout = (sat_h && !h_edge && !v_edge) || (sat_v && !v_edge);
        if (timeout) begin
            state_d     = SEARCH;
            good_d      = '0;
            ref_h_vld_d = 1'b0;
            ref_v_vld_d = 1'b0;
        end

        // Output stage is registered from next-state values so coordinates,
        // colour and edge pulses all land two clocks after the input.
        win         = (hc_d >= H_LO) && (hc_d < H_HI) && (vc_d >= V_LO) && (vc_d < V_HI);
        locked_d    = (state_d == LOCKED);
        pix_valid_d = win && locked_d;
        pix_x_d     = win ? hc_d - H_LO : pix_x_q;
        pix_y_d     = win ? vc_d - V_LO : pix_y_q;
        r_d         = pix_valid_d ? r_s1_q : 4'h0;
        g_d         = pix_valid_d ? g_s1_q : 4'h0;
        b_d         = pix_valid_d ? b_s1_q : 4'h0;
        line_start_d  = h_edge;
        frame_start_d = v_edge;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= SEARCH;
            r_s1_q        <= '0;  g_s1_q <= '0;  b_s1_q <= '0;
            hc_q          <= '0;  vc_q   <= '0;
            ref_h_q       <= '0;  ref_v_q <= '0;  good_q <= '0;
            ref_h_vld_q   <= 1'b0;
            ref_v_vld_q   <= 1'b0;
            err_q         <= 1'b0;
            pix_x_q       <= '0;  pix_y_q <= '0;
            h_total_q     <= '0;  v_total_q <= '0;
            pix_valid_q   <= 1'b0;
            locked_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            r_q           <= '0;  g_q <= '0;  b_q <= '0;
        end else begin
            state_q       <= state_d;
            r_s1_q        <= r_s1_d;  g_s1_q <= g_s1_d;  b_s1_q <= b_s1_d;
            hc_q          <= hc_d;    vc_q   <= vc_d;
            ref_h_q       <= ref_h_d; ref_v_q <= ref_v_d; good_q <= good_d;
            ref_h_vld_q   <= ref_h_vld_d;
            ref_v_vld_q   <= ref_v_vld_d;
            err_q         <= err_d;
            pix_x_q       <= pix_x_d; pix_y_q <= pix_y_d;
            h_total_q     <= h_total_d; v_total_q <= v_total_d;
            pix_valid_q   <= pix_valid_d;
            locked_q      <= locked_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            r_q           <= r_d;  g_q <= g_d;  b_q <= b_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
endmodule
